// File: rtl/serial_twos_decoder.sv
// -----------------------------------------------------------------------------
// serial_twos_decoder
//
// Bit-serial receiver for the stream produced by the serial two's-complement
// inverter. Bits arrive LSB first, one per strobed clock, framed as WIDTH-bit
// words. Each bit is passed up to and including the first 1, and inverted
// after it. Applying that rule again to the inverted stream recovers the
// original value. Each recovered word is presented in parallel, together with
// a one-cycle valid pulse.
//
// Parameters
//   WIDTH    bits per serial word (>= 2)
//   GAP_MAX  idle cycles tolerated inside a word before it is dropped (>= 1)
//
// Ports
//   t_clk    clock; all state updates on the rising edge
//   r        asynchronous active-high reset
//   i        serial data bit, LSB first
//   i_vld    i is valid this cycle and is sampled on the rising edge
//   o_word   recovered word; held until the next completed word
//   o_vld    one-cycle pulse: o_word was just updated
//   o_ovf    meaningful only with o_vld: the input word was the most-negative
//            value, so its negation cannot be represented
//   o_abort  one-cycle pulse: a partial word was dropped on gap timeout
//   o_busy   high while a word is partially received
// -----------------------------------------------------------------------------
module serial_twos_decoder #(
  parameter int WIDTH   = 4,
  parameter int GAP_MAX = 3
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic             i,
  input  logic             i_vld,
  output logic [WIDTH-1:0] o_word,
  output logic             o_vld,
  output logic             o_ovf,
  output logic             o_abort,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = $clog2(GAP_MAX + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LIMIT = GW'(GAP_MAX);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             seen_one;
  logic [WIDTH-1:0] shift_reg;

  logic             out_bit;
  logic [WIDTH-1:0] next_shift;

  // seen_one is always cleared when a word finishes or aborts, so in IDLE the
  // first bit of a word correctly passes through uninverted.
  assign out_bit    = seen_one ? ~i : i;
  assign next_shift = {out_bit, shift_reg[WIDTH-1:1]};

  // Receive FSM. Outputs are registered. The most-negative input is the only
  // word whose low WIDTH-1 bits are all zero and whose MSB is one. That case is
  // detected as "no 1 seen yet, and the final bit is 1".
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      seen_one  <= 1'b0;
      shift_reg <= '0;
      o_word    <= '0;
      o_vld     <= 1'b0;
      o_ovf     <= 1'b0;
      o_abort   <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_vld   <= 1'b0;
      o_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (i_vld) begin
            shift_reg <= next_shift;
            seen_one  <= i;
            bit_cnt   <= CW'(1);
            gap_cnt   <= '0;
            o_busy    <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (i_vld) begin
            shift_reg <= next_shift;
            gap_cnt   <= '0;
            if (bit_cnt == LAST_BIT) begin
              o_word   <= next_shift;
              o_vld    <= 1'b1;
              o_ovf    <= ~seen_one & i;
              seen_one <= 1'b0;
              bit_cnt  <= '0;
              o_busy   <= 1'b0;
              state    <= IDLE;
            end else begin
              seen_one <= seen_one | i;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end else if (gap_cnt == GAP_LIMIT) begin
            // This is idle cycle GAP_MAX+1, so the partial word is dropped.
            o_abort  <= 1'b1;
            seen_one <= 1'b0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            o_busy   <= 1'b0;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_twos_decoder.sv
// -----------------------------------------------------------------------------
// tb_serial_twos_decoder
//
// Self-checking bench for serial_twos_decoder with WIDTH=4 and GAP_MAX=3.
// Whenever stimulus that must produce an o_vld or o_abort pulse is driven, the
// expected event is pushed to a queue. A monitor pops one entry for every
// pulse the DUT produces and compares it.
// -----------------------------------------------------------------------------
module tb_serial_twos_decoder;

  localparam int WIDTH   = 4;
  localparam int GAP_MAX = 3;

  logic             t_clk = 1'b0;
  logic             r     = 1'b1;
  logic             i     = 1'b0;
  logic             i_vld = 1'b0;
  logic [WIDTH-1:0] o_word;
  logic             o_vld;
  logic             o_ovf;
  logic             o_abort;
  logic             o_busy;

  typedef struct {
    bit         is_abort;
    logic [3:0] word;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_vld_cyc = 0;
  int   vld_spacing  = 0;

  serial_twos_decoder #(.WIDTH(WIDTH), .GAP_MAX(GAP_MAX)) dut (
    .t_clk   (t_clk),
    .r       (r),
    .i       (i),
    .i_vld   (i_vld),
    .o_word  (o_word),
    .o_vld   (o_vld),
    .o_ovf   (o_ovf),
    .o_abort (o_abort),
    .o_busy  (o_busy)
  );

  always #5 t_clk = ~t_clk;

  always @(posedge t_clk) cyc <= cyc + 1;

  // One comparison: counts it, and reports tag/observed/expected on a miss.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every DUT pulse must match the oldest expectation.
  always @(negedge t_clk) begin
    if (o_vld || o_abort) begin
      check_output("vld_abort_exclusive", {31'd0, o_vld & o_abort}, 32'd0);
      check_output("pulse_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check_output("pulse_kind", {31'd0, o_abort}, {31'd0, e.is_abort});
        if (!e.is_abort) begin
          check_output("o_word", {28'd0, o_word}, {28'd0, e.word});
          check_output("o_ovf", {31'd0, o_ovf}, {31'd0, e.ovf});
        end
      end
      if (o_vld) begin
        vld_spacing  = cyc - last_vld_cyc;
        last_vld_cyc = cyc;
      end
    end
  end

  task automatic push_word(input logic [3:0] raw);
    exp_t e;
    e.is_abort = 1'b0;
    e.word     = 4'((16 - int'(raw)) % 16);
    e.ovf      = (raw == 4'b1000);
    sb.push_back(e);
  endtask

  task automatic push_abort();
    exp_t e;
    e.is_abort = 1'b1;
    e.word     = 4'd0;
    e.ovf      = 1'b0;
    sb.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    @(negedge t_clk);
    i     = b;
    i_vld = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge t_clk);
      i_vld = 1'b0;
      i     = 1'b0;
    end
  endtask

  // Drives one word LSB first, with a random gap of up to max_gap cycles
  // before each bit after the first.
  task automatic apply_stimulus(input logic [3:0] raw, input int max_gap);
    logic [3:0] w;
    w = raw;
    for (int b = 0; b < WIDTH; b++) begin
      if (b > 0 && max_gap > 0) idle($urandom_range(0, max_gap));
      if (b == WIDTH - 1) push_word(w);
      send_bit(w[b]);
    end
  endtask

  // Drops i_vld and waits, with a bounded number of cycles, for all
  // expected pulses to appear.
  task automatic drain();
    int n;
    idle(1);
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge t_clk);
      #1;
      n++;
    end
    check_output("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge t_clk);
    check_output("reset_word", {28'd0, o_word}, 32'd0);
    check_output("reset_vld", {31'd0, o_vld}, 32'd0);
    check_output("reset_busy", {31'd0, o_busy}, 32'd0);
    r = 1'b0;

    // Test 1: raw 1101 -> 0011.
    apply_stimulus(4'b1101, 0);
    drain();

    // Test 2: zero word, then the most-negative word.
    apply_stimulus(4'b0000, 0);
    apply_stimulus(4'b1000, 0);
    drain();

    // Test 3: back-to-back words, with no bubble between them.
    apply_stimulus(4'b1110, 0);
    apply_stimulus(4'b1111, 0);
    drain();
    check_output("b2b_spacing", vld_spacing, 32'd4);

    // Test 4a: a 2-cycle gap inside a word is invisible in o_word.
    send_bit(1'b1);
    send_bit(1'b0);
    idle(2);
    send_bit(1'b1);
    push_word(4'b1101);
    send_bit(1'b1);
    drain();

    // Test 4b: a GAP_MAX-cycle gap is still tolerated.
    send_bit(1'b0);
    idle(GAP_MAX);
    send_bit(1'b1);
    send_bit(1'b0);
    push_word(4'b0010);
    send_bit(1'b0);
    drain();

    // Test 4c: a gap of GAP_MAX+1 cycles aborts; the next word still decodes.
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge t_clk);
    i_vld = 1'b0;
    check_output("busy_mid_word", {31'd0, o_busy}, 32'd1);
    push_abort();
    idle(GAP_MAX + 1);
    drain();
    check_output("busy_after_abort", {31'd0, o_busy}, 32'd0);
    apply_stimulus(4'b0110, 0);
    drain();

    // Test 5: asynchronous reset mid-word.
    send_bit(1'b1);
    send_bit(1'b0);
    @(posedge t_clk);
    #2;
    i_vld = 1'b0;
    check_output("busy_before_reset", {31'd0, o_busy}, 32'd1);
    r = 1'b1;
    #1;
    check_output("async_reset_word", {28'd0, o_word}, 32'd0);
    check_output("async_reset_busy", {31'd0, o_busy}, 32'd0);
    check_output("async_reset_pulses", {30'd0, o_vld, o_abort}, 32'd0);
    repeat (2) @(negedge t_clk);
    r = 1'b0;
    apply_stimulus(4'b0011, 0);
    drain();

    // Test 6: all 16 raw words, with random gaps of up to GAP_MAX cycles.
    for (int w = 0; w < 16; w++) begin
      apply_stimulus(4'(w), GAP_MAX);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
